// File: rtl/tdm_run_detector_pkg.sv
// tdm_det_pkg
//   Shared definitions for the time-multiplexed run detector.
//   - det_state_t : per-channel detector context.
//                   A = no trailing one, B = one trailing one,
//                   C = two or more trailing ones (hit).
//   - det_next    : next-state function applied to one accepted bit.
//   - default channel count and hit-counter width.
package tdm_det_pkg;

  localparam int NCH_DEFAULT   = 4;
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    A = 2'b00,
    B = 2'b01,
    C = 2'b10
  } det_state_t;

  // The argument is a raw 2-bit code so that the unused code 2'b11 can be
  // handled explicitly. That code recovers to A whatever the input bit is.
  function automatic det_state_t det_next(input logic [1:0] cur, input logic w);
    det_state_t n;
    case (cur)
      2'b00:   n = w ? B : A;
      2'b01:   n = w ? C : A;
      2'b10:   n = w ? C : A;
      default: n = A;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tdm_run_detector_rr_arbiter.sv
// rr_arbiter
//   Round-robin single-grant arbiter. It is purely combinational and the
//   pointer register lives in the parent.
//   Ports:
//     eligible  in  NCH  requests that may be granted this cycle
//     rr_ptr    in  CW   highest-priority index for this cycle
//     xfer      in  1    a transfer happens this cycle (advance pointer)
//     grant     out NCH  one-hot grant, zero when nothing is eligible
//     grant_idx out CW   encoded grant index (0 when no grant)
//     ptr_next  out CW   pointer value for the next cycle
module rr_arbiter #(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] eligible,
  input  logic [CW-1:0]  rr_ptr,
  input  logic           xfer,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  grant_idx,
  output logic [CW-1:0]  ptr_next
);

  // Scan NCH positions starting at rr_ptr, wrapping modulo NCH. The first
  // eligible position wins.
  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CW'(idx);
      end
    end
  end

  // The granted channel drops to lowest priority. The wrap is explicit
  // because NCH need not be a power of two.
  always_comb begin
    ptr_next = rr_ptr;
    if (xfer) begin
      if (int'(grant_idx) == NCH - 1) ptr_next = '0;
      else                            ptr_next = grant_idx + CW'(1);
    end
  end

endmodule

// File: rtl/tdm_run_detector.sv
// tdm_run_detector
//   Shares one "two-or-more consecutive ones" detector across NCH serial bit
//   channels. Each cycle a round-robin arbiter grants at most one channel.
//   The granted channel's saved context is advanced by its bit and written
//   back, and a registered result stream reports the channel and hit status.
//
//   Handshake: a channel's bit transfers in a cycle where in_valid[i] and
//   in_ready[i] are both high. in_ready is a combinational one-hot grant.
//   The source must hold in_valid/in_bit until the transfer happens.
//   Asserting chan_clr[i] removes channel i from arbitration for that cycle
//   and returns its context to A.
//
//   Ports:
//     clk, reset  in        clock, synchronous active-high reset
//     in_valid    in  NCH   channel has a bit to deliver
//     in_bit      in  NCH   bit value per channel
//     in_ready    out NCH   one-hot/zero grant (forced 0 during reset)
//     chan_clr    in  NCH   per-channel synchronous context clear
//     out_valid   out 1     a transfer happened last cycle
//     out_chan    out CW    channel of that transfer (holds otherwise)
//     out_hit     out 1     that channel's new state is C (holds otherwise)
//     chan_hit    out NCH   registered per-channel (state == C)
//     stat_sel    in  CW    counter select        (TDM_DET_STATS_EN only)
//     stat_cnt    out CNT_W selected hit counter  (TDM_DET_STATS_EN only)
//     state_dbg   out 2*NCH per-channel context, channel i at [2i+1:2i]
//     rr_ptr_dbg  out CW    current round-robin pointer
//
//   Optional feature macro TDM_DET_STATS_EN adds per-channel saturating hit
//   counters and the stat_sel/stat_cnt ports.
module tdm_run_detector
  import tdm_det_pkg::*;
#(
  parameter  int NCH   = NCH_DEFAULT,
  parameter  int CNT_W = CNT_W_DEFAULT,
  localparam int CW    = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH-1:0]   in_bit,
  output logic [NCH-1:0]   in_ready,
  input  logic [NCH-1:0]   chan_clr,
  output logic             out_valid,
  output logic [CW-1:0]    out_chan,
  output logic             out_hit,
  output logic [NCH-1:0]   chan_hit,
`ifdef TDM_DET_STATS_EN
  input  logic [CW-1:0]    stat_sel,
  output logic [CNT_W-1:0] stat_cnt,
`endif
  output logic [2*NCH-1:0] state_dbg,
  output logic [CW-1:0]    rr_ptr_dbg
);

  det_state_t     state_q [NCH];
  det_state_t     state_d [NCH];
  det_state_t     grant_next;
  logic [CW-1:0]  rr_ptr_q;
  logic [CW-1:0]  rr_ptr_d;
  logic [CW-1:0]  grant_idx;
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] grant;
  logic [NCH-1:0] chan_hit_d;
  logic           xfer;

  // ---------------------------------------------------------------------
  // Arbitration. A clear excludes its channel, so a clear always beats a
  // grant on that channel. The other channels still compete.
  // ---------------------------------------------------------------------
  assign eligible = in_valid & ~chan_clr;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .xfer      (xfer),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ptr_next  (rr_ptr_d)
  );

  assign in_ready = reset ? '0 : grant;
  assign xfer     = |(in_valid & in_ready);

  // Next context of the granted channel. The grant is one-hot, so at most
  // one loop iteration matches.
  always_comb begin
    grant_next = A;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) grant_next = det_next(state_q[i], in_bit[i]);
    end
  end

  // ---------------------------------------------------------------------
  // Context FSMs: state register / next-state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) state_q[i] <= A;
      rr_ptr_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) state_q[i] <= state_d[i];
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      if (chan_clr[i])           state_d[i] = A;
      else if (xfer && grant[i]) state_d[i] = grant_next;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      chan_hit_d[i]       = (state_d[i] == C);
      state_dbg[2*i +: 2] = state_q[i];
    end
    rr_ptr_dbg = rr_ptr_q;
  end

  // ---------------------------------------------------------------------
  // Result stream. out_chan and out_hit keep the last transfer's values.
  // chan_hit follows the written-back context on the same edge.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_hit   <= 1'b0;
      chan_hit  <= '0;
    end else begin
      out_valid <= xfer;
      if (xfer) begin
        out_chan <= grant_idx;
        out_hit  <= (grant_next == C);
      end
      chan_hit <= chan_hit_d;
    end
  end

`ifdef TDM_DET_STATS_EN
  // ---------------------------------------------------------------------
  // Per-channel saturating hit counters
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q [NCH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (chan_clr[i]) begin
          cnt_q[i] <= '0;
        end else if (xfer && grant[i] && (grant_next == C) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // An out-of-range select (non-power-of-two NCH) reads as zero.
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (stat_sel == CW'(i)) stat_cnt = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_tdm_run_detector.sv
module tb_tdm_run_detector;

  localparam int NCH   = 4;
  localparam int CW    = 2;
  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_bit;
  logic [NCH-1:0]   in_ready;
  logic [NCH-1:0]   chan_clr;
  logic             out_valid;
  logic [CW-1:0]    out_chan;
  logic             out_hit;
  logic [NCH-1:0]   chan_hit;
  logic [2*NCH-1:0] state_dbg;
  logic [CW-1:0]    rr_ptr_dbg;
`ifdef TDM_DET_STATS_EN
  logic [CW-1:0]    stat_sel;
  logic [CNT_W-1:0] stat_cnt;
`endif

  tdm_run_detector #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .chan_clr   (chan_clr),
    .out_valid  (out_valid),
    .out_chan   (out_chan),
    .out_hit    (out_hit),
    .chan_hit   (chan_hit),
`ifdef TDM_DET_STATS_EN
    .stat_sel   (stat_sel),
    .stat_cnt   (stat_cnt),
`endif
    .state_dbg  (state_dbg),
    .rr_ptr_dbg (rr_ptr_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [CW:0] exp_q[$];    // {chan, hit} per expected result
  int m_run [NCH];          // trailing-ones run length, saturating at 2
  int m_cnt [NCH];          // hit counts, saturating at 255
  int m_ptr;

  logic [NCH-1:0] obs_ready;
  logic           obs_valid;
  logic           obs_hit;
  logic [CW-1:0]  obs_chan;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive inputs, check in_ready mid-cycle, update model,
  // then check registered outputs just after the edge.
  task automatic cycle(input logic rst, input logic [NCH-1:0] v,
                       input logic [NCH-1:0] b, input logic [NCH-1:0] clr);
    logic [NCH-1:0]   exp_ready;
    logic [NCH-1:0]   exp_hitv;
    logic [2*NCH-1:0] exp_st;
    logic [CW:0]      item;
    int g;
    reset    = rst;
    in_valid = v;
    in_bit   = b;
    chan_clr = clr;
    exp_ready = '0;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        int idx;
        idx = (m_ptr + k) % NCH;
        if (g < 0 && v[idx] && !clr[idx]) g = idx;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;

    @(negedge clk);
    obs_ready = in_ready;
    checks++;
    if (in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b", in_ready, exp_ready);
    end

    if (rst) begin
      for (int i = 0; i < NCH; i++) begin m_run[i] = 0; m_cnt[i] = 0; end
      m_ptr = 0;
      exp_q.delete();
    end else begin
      if (g >= 0) begin
        m_run[g] = b[g] ? ((m_run[g] >= 2) ? 2 : m_run[g] + 1) : 0;
        exp_q.push_back({CW'(g), (m_run[g] >= 2)});
        if (m_run[g] >= 2 && m_cnt[g] < 255) m_cnt[g]++;
        m_ptr = (g + 1) % NCH;
      end
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin m_run[i] = 0; m_cnt[i] = 0; end
      end
    end

    @(posedge clk);
    #1;
    obs_valid = out_valid;
    obs_chan  = out_chan;
    obs_hit   = out_hit;

    checks++;
    if (out_valid !== ((!rst && g >= 0) ? 1'b1 : 1'b0)) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", out_valid, (!rst && g >= 0));
    end
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_stream: got chan %0d hit %b expected no result", out_chan, out_hit);
      end else begin
        item = exp_q.pop_front();
        if ({out_chan, out_hit} !== item) begin
          errors++;
          $display("FAIL result: got chan %0d hit %b expected chan %0d hit %b",
                   out_chan, out_hit, item[CW:1], item[0]);
        end
      end
    end

    for (int i = 0; i < NCH; i++) begin
      exp_hitv[i]      = (m_run[i] >= 2);
      exp_st[2*i +: 2] = (m_run[i] >= 2) ? 2'b10 : (m_run[i] == 1) ? 2'b01 : 2'b00;
    end
    checks++;
    if (chan_hit !== exp_hitv) begin
      errors++;
      $display("FAIL chan_hit: got %b expected %b", chan_hit, exp_hitv);
    end
    checks++;
    if (state_dbg !== exp_st) begin
      errors++;
      $display("FAIL state: got %b expected %b", state_dbg, exp_st);
    end
    checks++;
    if (rr_ptr_dbg !== CW'(m_ptr)) begin
      errors++;
      $display("FAIL rr_ptr: got %0d expected %0d", rr_ptr_dbg, m_ptr);
    end
`ifdef TDM_DET_STATS_EN
    checks++;
    if (stat_cnt !== CNT_W'(m_cnt[stat_sel])) begin
      errors++;
      $display("FAIL stat_cnt: got %0d expected %0d", stat_cnt, m_cnt[stat_sel]);
    end
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cycle(1'b1, '0, '0, '0);
    cycle(1'b1, 4'b1111, 4'b1111, '0);
    checks++;
    if (out_chan !== 2'd0 || out_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got chan %0d hit %b expected chan 0 hit 0", out_chan, out_hit);
    end
  endtask

  task automatic test_single_channel();
    logic [3:0] bits;
    logic [3:0] hits;
    bits = 4'b0111;   // bit k is the k-th bit sent: 1,1,1,0
    hits = '0;
    cycle(1'b1, '0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 4'b0001, {3'b000, bits[k]}, '0);
      hits[k] = obs_hit;
      if (k == 2) begin
        checks++;
        if (chan_hit[0] !== 1'b1) begin
          errors++;
          $display("FAIL single_hit_high: got %b expected 1", chan_hit[0]);
        end
      end
    end
    checks++;
    if (hits !== 4'b0110) begin
      errors++;
      $display("FAIL single_hits: got %b expected 0110", hits);
    end
    checks++;
    if (chan_hit[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_hit_fall: got %b expected 0", chan_hit[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [NCH-1:0] exp_rdy [5];
    int             exp_ch  [5];
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_ch  = '{0, 1, 2, 3, 0};
    cycle(1'b1, '0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 4'b1111, 4'($urandom_range(0, 15)), '0);
      checks++;
      if (obs_ready !== exp_rdy[k] || obs_chan !== CW'(exp_ch[k])) begin
        errors++;
        $display("FAIL round_robin[%0d]: got ready %b chan %0d expected ready %b chan %0d",
                 k, obs_ready, obs_chan, exp_rdy[k], exp_ch[k]);
      end
    end
  endtask

  task automatic test_clear_beats_grant();
    cycle(1'b1, '0, '0, '0);
    cycle(1'b0, 4'b0100, 4'b0100, '0);
    cycle(1'b0, 4'b0100, 4'b0100, '0);
    checks++;
    if (chan_hit[2] !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup: got chan_hit[2] %b expected 1", chan_hit[2]);
    end
    cycle(1'b0, 4'b1100, 4'b0100, 4'b0100);
    checks++;
    if (obs_ready !== 4'b1000 || obs_chan !== 2'd3 || chan_hit[2] !== 1'b0
        || state_dbg[5:4] !== 2'b00) begin
      errors++;
      $display("FAIL clr_beats_grant: got ready %b chan %0d hit2 %b st2 %b expected 1000 3 0 00",
               obs_ready, obs_chan, chan_hit[2], state_dbg[5:4]);
    end
  endtask

  task automatic test_interleave();
    logic [NCH-1:0] v   [4];
    logic [NCH-1:0] b   [4];
    logic [3:0]     hits;
    logic [7:0]     chans;
    v = '{4'b1010, 4'b1010, 4'b1010, 4'b1000};
    b = '{4'b1010, 4'b1010, 4'b0010, 4'b0000};
    hits = '0;
    chans = '0;
    cycle(1'b1, '0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, v[k], b[k], '0);
      hits[k]         = obs_hit;
      chans[2*k +: 2] = obs_chan;
    end
    checks++;
    if (hits !== 4'b0100 || chans !== 8'b11_01_11_01) begin
      errors++;
      $display("FAIL interleave: got hits %b chans %b expected 0100 11011101", hits, chans);
    end
  endtask

  task automatic test_midstream_reset();
    cycle(1'b1, '0, '0, '0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 4'b0111, 4'b0111, '0);
    checks++;
    if (chan_hit !== 4'b0111) begin
      errors++;
      $display("FAIL pre_reset_hits: got %b expected 0111", chan_hit);
    end
    cycle(1'b1, 4'b0111, 4'b0111, '0);
    checks++;
    if (obs_ready !== 4'b0000 || out_valid !== 1'b0 || state_dbg !== 8'h00 || rr_ptr_dbg !== 2'd0) begin
      errors++;
      $display("FAIL midstream_reset: got ready %b valid %b state %h ptr %0d expected 0000 0 00 0",
               obs_ready, out_valid, state_dbg, rr_ptr_dbg);
    end
    cycle(1'b0, 4'b0010, 4'b0010, '0);
    checks++;
    if (obs_valid !== 1'b1 || obs_chan !== 2'd1 || obs_hit !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_first: got valid %b chan %0d hit %b expected 1 1 0",
               obs_valid, obs_chan, obs_hit);
    end
  endtask

  task automatic test_back_to_back();
    logic [NCH-1:0] v;
    logic [NCH-1:0] clr;
    cycle(1'b1, '0, '0, '0);
    for (int k = 0; k < 60; k++) begin
      v   = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      cycle(1'b0, v, 4'($urandom_range(0, 15)), clr);
    end
  endtask

`ifdef TDM_DET_STATS_EN
  task automatic test_stats();
    stat_sel = '0;
    cycle(1'b1, '0, '0, '0);
    for (int k = 0; k < 300; k++) begin
      cycle(1'b0, 4'b0001, 4'b0001, '0);
      if (k == 9) begin
        checks++;
        if (stat_cnt !== 8'd9) begin
          errors++;
          $display("FAIL stats_count: got %0d expected 9", stat_cnt);
        end
      end
    end
    checks++;
    if (stat_cnt !== 8'd255) begin
      errors++;
      $display("FAIL stats_saturate: got %0d expected 255", stat_cnt);
    end
    cycle(1'b0, 4'b0000, 4'b0000, 4'b0001);
    checks++;
    if (stat_cnt !== 8'd0) begin
      errors++;
      $display("FAIL stats_clear: got %0d expected 0", stat_cnt);
    end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    for (int i = 0; i < NCH; i++) begin m_run[i] = 0; m_cnt[i] = 0; end
    m_ptr = 0;
`ifdef TDM_DET_STATS_EN
    stat_sel = '0;
`endif
    test_reset();
    test_single_channel();
    test_round_robin();
    test_clear_beats_grant();
    test_interleave();
    test_midstream_reset();
    test_back_to_back();
`ifdef TDM_DET_STATS_EN
    test_stats();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending results expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
